// File: rtl/sorting_result_serializer_if.sv
// Bus between the sorting network, the result serializer and its consumer.
// The serializer sits on the slave side; the environment drives the master side.
interface sorting_result_serializer_if #(
    parameter int LOG_INPUT_NUM = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int LABEL_WIDTH   = 4
);
    localparam int N = 2 ** LOG_INPUT_NUM;

    logic                     x_valid;
    logic [DATA_WIDTH*N-1:0]  x;
    logic [LABEL_WIDTH*N-1:0] x_label;
    logic [DATA_WIDTH-1:0]    y;
    logic [LABEL_WIDTH-1:0]   y_label;
    logic                     y_valid;
    logic                     y_ready;
    logic                     y_last;

    modport master (
        output x_valid, x, x_label, y_ready,
        input  y, y_label, y_valid, y_last
    );

    modport slave (
        input  x_valid, x, x_label, y_ready,
        output y, y_label, y_valid, y_last
    );
endinterface

// File: rtl/sorting_result_serializer.sv
// Buffers sorted vectors from the bitonic network in two slots and streams the
// first OUTPUT_NUM elements of each one per beat; vectors arriving when full are dropped.
module sorting_result_serializer #(
    parameter int LOG_INPUT_NUM  = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int LABEL_WIDTH    = 4,
    parameter int OUTPUT_NUM     = 2 ** LOG_INPUT_NUM,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    sorting_result_serializer_if.slave bus,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
    localparam int N     = 2 ** LOG_INPUT_NUM;
    localparam int IDX_W = (LOG_INPUT_NUM > 0) ? LOG_INPUT_NUM : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_NUM - 1);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [DATA_WIDTH-1:0]  slot_data  [2][N];
    logic [LABEL_WIDTH-1:0] slot_label [2][N];

    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [IDX_W-1:0] elem_idx;

    logic fire;
    logic pop;
    logic accept;
    logic drop;

    assign fire   = bus.y_valid & bus.y_ready;
    assign pop    = fire & (elem_idx == LAST_IDX);
    // The final beat of the head vector frees a slot in time for a same-cycle arrival.
    assign accept = bus.x_valid & ((count <= ONE) | pop);
    assign drop   = bus.x_valid & (count == FULL) & ~pop;

    assign bus.y_valid = (count != EMPTY);
    assign bus.y_last  = bus.y_valid & (elem_idx == LAST_IDX);
    assign bus.y       = slot_data[rd_ptr][elem_idx];
    assign bus.y_label = slot_label[rd_ptr][elem_idx];

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                slot_data[wr_ptr][i]  <= bus.x[DATA_WIDTH*i +: DATA_WIDTH];
                slot_label[wr_ptr][i] <= bus.x_label[LABEL_WIDTH*i +: LABEL_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            elem_idx <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fire) begin
                if (pop) begin
                    elem_idx <= '0;
                    rd_ptr   <= ~rd_ptr;
                end else begin
                    elem_idx <= elem_idx + 1'b1;
                end
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Drop counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            overflow <= drop;
            if (drop && (drop_cnt != {DROP_CNT_WIDTH{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/sorting_result_serializer.md
Name: sorting_result_serializer

Overview:
Downstream companion of the bitonic sorting network. Captures each sorted output vector (data plus labels) in a 2-slot vector buffer. Streams the first OUTPUT_NUM elements of each vector one element per beat over a valid/ready interface. The sorting network has no backpressure, so vectors arriving while both slots are occupied are dropped and counted.

Parameters:
LOG_INPUT_NUM, 4, vector holds N = 2**LOG_INPUT_NUM elements
DATA_WIDTH, 8, width of one data element
LABEL_WIDTH, 4, width of one label
OUTPUT_NUM, 2**LOG_INPUT_NUM, elements emitted per vector (top-K); legal range 1..N
DROP_CNT_WIDTH, 8, width of the saturating drop counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
x_valid  input  1  sorted vector present on x/x_label this cycle (single-cycle qualifier)
x  input  DATA_WIDTH*N  sorted data; element i at x[DATA_WIDTH*(i+1)-1:DATA_WIDTH*i]
x_label  input  LABEL_WIDTH*N  labels, same packing as x
y  output  DATA_WIDTH  current element
y_label  output  LABEL_WIDTH  label of current element
y_valid  output  1  y/y_label/y_last valid
y_ready  input  1  consumer accepts beat
y_last  output  1  current beat is element OUTPUT_NUM-1 of its vector
overflow  output  1  one-cycle pulse, vector dropped
drop_cnt  output  DROP_CNT_WIDTH  count of dropped vectors, saturating

Behaviour:
- Reset (rst=0, async):
  - State: occupancy count=0, wr_ptr=0, rd_ptr=0, elem_idx=0.
  - Outputs: y_valid=0, y_last=0, overflow=0, drop_cnt=0.
  - y and y_label are don't-care while y_valid=0. Buffer storage is not reset.
  - Reset mid-stream discards both slots and any partially sent vector.
- Occupancy states: EMPTY (count 0), ONE (count 1), FULL (count 2).
- Beat handshake:
  - fire = y_valid & y_ready.
  - pop = fire & (elem_idx == OUTPUT_NUM-1).
- Accept rule: vector accepted when x_valid & (count<2 | pop).
  - On accept, write to slot[wr_ptr] and toggle wr_ptr.
  - A vector arriving in FULL on the same cycle as the final beat of the head vector is accepted.
- Drop rule: x_valid & count==2 & !pop.
  - Vector is discarded.
  - overflow=1 in the following cycle only.
  - drop_cnt increments, holding at 2**DROP_CNT_WIDTH-1.
- Count update: count_next = count + accept - pop (push and pop in the same cycle leaves count unchanged).
- Output datapath: y/y_label are combinational mux of slot[rd_ptr] element elem_idx.
  - y_valid = (count != 0).
  - y_last = y_valid & (elem_idx == OUTPUT_NUM-1).
- Latency: a vector accepted at edge k in EMPTY presents element 0 with y_valid=1 from edge k (visible in cycle k+1). No extra pipeline delay.
- Emission order: elements 0,1,...,OUTPUT_NUM-1 in ascending index order. Elements OUTPUT_NUM..N-1 are never emitted.
- On fire:
  - If not last: elem_idx increments.
  - If last: elem_idx returns to 0, rd_ptr toggles, count decrements (unless a push occurs the same cycle).
- Stability: while y_valid & !y_ready, y/y_label/y_last and elem_idx are held. An incoming vector never alters the head slot.
- Sustained throughput: one beat per cycle while y_ready=1. Back-to-back vectors stream with no bubble between y_last of one vector and element 0 of the next.
- x_valid in EMPTY with y_ready=1: element 0 is presented the next cycle, never in the same cycle (no combinational x->y path).
- OUTPUT_NUM=1: every beat has y_last=1 and pops.
- elem_idx width is max(1, LOG_INPUT_NUM). Arithmetic on pointers/counters is unsigned. drop_cnt saturates and does not wrap.

Test Plan:
- Single vector: LOG_INPUT_NUM=2, x elements {10,20,30,40}, labels {0,1,2,3}, y_ready=1 -> beats 10/0, 20/1, 30/2, 40/3 on 4 consecutive cycles starting the cycle after accept; y_last only on 40; then y_valid=0.
- Backpressure: same vector, y_ready pattern 1,0,0,1,1,0,1 -> exactly 4 beats in order 10, 20, 30, 40; y/y_label constant during every stall cycle.
- Overflow: three vectors A, B, C on consecutive cycles with y_ready=0 -> A and B stored; overflow pulses once the cycle after C; drop_cnt=1. Raising y_ready then yields 8 beats A0..A3, B0..B3.
- Simultaneous push/pop: FULL, drive x_valid on the same cycle as the final beat of head vector A -> no overflow; drop_cnt unchanged; B then new vector streamed with no bubble.
- Top-K: OUTPUT_NUM=2 with vectors {5,6,7,8} then {1,2,3,4} back-to-back, y_ready=1 -> beats 5, 6, 1, 2; y_last on 6 and 2.
- Reset mid-stream: assert rst=0 after 2 beats of a vector -> y_valid=0 and drop_cnt=0 immediately. After release, a new vector starts at element 0; no stale beats appear.
